// File: rtl/spi_arb_pkg.sv
//------------------------------------------------------------------------------
// spi_arb_pkg
// Shared definitions for the SPI transmit arbiter:
//   - arb_state_t     : arbiter state encoding (IDLE, LOCK, GAP)
//   - GRANT_*         : one-hot grant constants, GRANT_NONE when nobody owns
//   - GAP_CNT_W       : width of the inter-transaction gap counter
//   - grant_owner_is_1: decodes which requester a one-hot grant points at
//------------------------------------------------------------------------------
package spi_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOCK = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_t;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_0    = 2'b01;
   localparam logic [1:0] GRANT_1    = 2'b10;

   localparam int GAP_CNT_W = 4;

   // Owner decode: bit 1 set means requester 1 holds the lock, anything else
   // (including no grant) routes the requester-0 datapath.
   function automatic logic grant_owner_is_1(input logic [1:0] grant_v);
      return grant_v[1];
   endfunction

endpackage

// File: rtl/spi_arb_pick.sv
//------------------------------------------------------------------------------
// spi_arb_pick
// Two-request winner selection. This is the only place tie-breaking happens.
// Ports:
//   req0, req1 : request lines (valid from each requester)
//   prio       : tie-break preference, 0 = requester 0 wins ties,
//                1 = requester 1 wins ties
//   winner     : one-hot winner, GRANT_NONE when neither requests
//------------------------------------------------------------------------------
module spi_arb_pick
   import spi_arb_pkg::*;
(
   input  logic       req0,
   input  logic       req1,
   input  logic       prio,
   output logic [1:0] winner
);

   // Winner selection: a lone requester always wins, ties follow prio.
   always_comb begin
      winner = GRANT_NONE;
      if (req0 && req1) begin
         if (prio) begin
            winner = GRANT_1;
         end else begin
            winner = GRANT_0;
         end
      end else if (req0) begin
         winner = GRANT_0;
      end else if (req1) begin
         winner = GRANT_1;
      end else begin
         winner = GRANT_NONE;
      end
   end

endmodule

// File: rtl/spi_tx_arbiter.sv
//------------------------------------------------------------------------------
// spi_tx_arbiter
// Arbitrates two byte-stream requesters onto one SPI master transmit port.
// A winner locks the port until it sends a byte flagged last (CS release),
// so chip-select framing of two requesters is never interleaved. After a
// transaction an idle gap of GAP_CYCLES cycles is enforced before the next
// grant. Bytes are not buffered: in LOCK the owner's valid/byte/last are
// passed straight through and its ready mirrors spi_tx_ready.
//
// Parameters:
//   GAP_CYCLES       idle cycles between transactions (0..15)
// Configuration macro:
//   SPI_TX_ARBITER_ROUND_ROBIN_EN  defined   -> ties alternate between
//                                               requesters (pointer register)
//                                  undefined -> requester 0 always wins ties
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   reqN_valid/byte/last/ready     requester N byte stream (N = 0, 1)
//   spi_tx_ready                   SPI master can accept a byte
//   spi_tx_valid/byte/clear_cs     byte offered to the SPI master
//   grant                          one-hot current owner, 2'b00 when none
//   busy                           high whenever the arbiter is not IDLE
//------------------------------------------------------------------------------
module spi_tx_arbiter
   import spi_arb_pkg::*;
#(
   parameter int GAP_CYCLES = 2
)
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_byte,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_byte,
   input  logic       req1_last,
   output logic       req1_ready,
   input  logic       spi_tx_ready,
   output logic       spi_tx_valid,
   output logic [7:0] spi_tx_byte,
   output logic       spi_tx_clear_cs,
   output logic [1:0] grant,
   output logic       busy
);

   // Last count value spent in GAP; unused when the gap is disabled.
   localparam logic [GAP_CNT_W-1:0] GAP_LAST_C = 4'(GAP_CYCLES - 1);
   localparam logic                 GAP_EN_C   = (GAP_CYCLES > 0) ? 1'b1 : 1'b0;

   arb_state_t           state_r;
   arb_state_t           state_next_s;
   logic [1:0]           grant_r;
   logic [1:0]           grant_next_s;
   logic [GAP_CNT_W-1:0] gap_cnt_r;
   logic [GAP_CNT_W-1:0] gap_cnt_next_s;
   logic                 busy_r;
   logic                 armed_r;
   logic                 prio_s;
   logic [1:0]           pick_s;
   logic                 owner_is_1_s;
   logic                 owner_valid_s;
   logic [7:0]           owner_byte_s;
   logic                 owner_last_s;
   logic                 xfer_s;
   logic                 grant_issue_s;

   spi_arb_pick u_pick (
      .req0   (req0_valid),
      .req1   (req1_valid),
      .prio   (prio_s),
      .winner (pick_s)
   );

`ifdef SPI_TX_ARBITER_ROUND_ROBIN_EN
   logic ptr_r;

   // Tie-break pointer: after every grant, prefer the requester that did
   // not just win, so simultaneous requests alternate.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_r <= 1'b0;
      end else if (grant_issue_s) begin
         ptr_r <= pick_s[0];
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign prio_s = ptr_r;
`else
   assign prio_s = 1'b0;
`endif

   // Owner datapath mux, steered by the registered grant.
   always_comb begin
      owner_is_1_s = grant_owner_is_1(grant_r);
      if (owner_is_1_s) begin
         owner_valid_s = req1_valid;
         owner_byte_s  = req1_byte;
         owner_last_s  = req1_last;
      end else begin
         owner_valid_s = req0_valid;
         owner_byte_s  = req0_byte;
         owner_last_s  = req0_last;
      end
   end

   // A byte moves when the lock owner is valid and the SPI master is ready.
   assign xfer_s = (state_r == ST_LOCK) && owner_valid_s && spi_tx_ready;

   // armed_r blocks the first edge after reset release from granting.
   assign grant_issue_s = (state_r == ST_IDLE) && armed_r && (pick_s != GRANT_NONE);

   // Next-state logic: grant in IDLE, hold lock until a last byte moves,
   // then count out the gap.
   always_comb begin
      state_next_s   = state_r;
      grant_next_s   = grant_r;
      gap_cnt_next_s = gap_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_issue_s) begin
               grant_next_s = pick_s;
               state_next_s = ST_LOCK;
            end else begin
               grant_next_s = GRANT_NONE;
               state_next_s = ST_IDLE;
            end
         end
         ST_LOCK: begin
            if (xfer_s && owner_last_s) begin
               grant_next_s   = GRANT_NONE;
               gap_cnt_next_s = {GAP_CNT_W{1'b0}};
               if (GAP_EN_C) begin
                  state_next_s = ST_GAP;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end else begin
               state_next_s = ST_LOCK;
            end
         end
         ST_GAP: begin
            if (gap_cnt_r == GAP_LAST_C) begin
               gap_cnt_next_s = {GAP_CNT_W{1'b0}};
               state_next_s   = ST_IDLE;
            end else begin
               gap_cnt_next_s = gap_cnt_r + 4'd1;
               state_next_s   = ST_GAP;
            end
         end
         default: begin
            state_next_s   = ST_IDLE;
            grant_next_s   = GRANT_NONE;
            gap_cnt_next_s = {GAP_CNT_W{1'b0}};
         end
      endcase
   end

   // Output decode: only the lock owner sees ready; SPI side is a
   // pass-through of the owner while locked and quiet otherwise.
   always_comb begin
      spi_tx_valid    = 1'b0;
      spi_tx_byte     = 8'h00;
      spi_tx_clear_cs = 1'b0;
      req0_ready      = 1'b0;
      req1_ready      = 1'b0;
      case (state_r)
         ST_LOCK: begin
            spi_tx_valid    = owner_valid_s;
            spi_tx_byte     = owner_byte_s;
            spi_tx_clear_cs = owner_last_s;
            if (owner_is_1_s) begin
               req1_ready = spi_tx_ready;
            end else begin
               req0_ready = spi_tx_ready;
            end
         end
         ST_IDLE, ST_GAP: begin
            spi_tx_valid = 1'b0;
         end
         default: begin
            spi_tx_valid = 1'b0;
         end
      endcase
   end

   // State, grant, gap counter and busy registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         grant_r   <= GRANT_NONE;
         gap_cnt_r <= {GAP_CNT_W{1'b0}};
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         grant_r   <= grant_next_s;
         gap_cnt_r <= gap_cnt_next_s;
         busy_r    <= (state_next_s != ST_IDLE);
      end
   end

   // Arms granting one edge after reset release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         armed_r <= 1'b0;
      end else begin
         armed_r <= 1'b1;
      end
   end

   assign grant = grant_r;
   assign busy  = busy_r;

endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameter: GAP_CYCLES, 2, idle cycles enforced between the end of one transaction and the next grant (range 0-15).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has a byte to send.
REQ-005 req0_byte  input  8  requester 0 data byte.
REQ-006 req0_last  input  1  requester 0: deassert CS after this byte (ends transaction).
REQ-007 req0_ready  output  1  requester 0 byte accepted this cycle when high with req0_valid.
REQ-008 req1_valid / req1_byte / req1_last / req1_ready  same directions, widths and meanings as requester 0.
REQ-009 spi_tx_ready  input  1  SPI master idle and able to accept a byte.
REQ-010 spi_tx_valid  output  1  byte offered to SPI master.
REQ-011 spi_tx_byte  output  8  byte to SPI master.
REQ-012 spi_tx_clear_cs  output  1  forwarded last flag of offered byte.
REQ-013 grant  output  2  one-hot current owner; 2'b00 when none.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 A byte SHALL transfer on a rising edge where spi_tx_valid and spi_tx_ready are both high; the owner's reqN_ready SHALL equal spi_tx_ready in that cycle.
REQ-016 States SHALL be IDLE, LOCK, GAP.
REQ-017 IDLE: when any reqN_valid is high, a winner SHALL be selected, grant registered, and the state SHALL move to LOCK on the next edge; spi_tx_valid SHALL be 0 in IDLE (1-cycle grant latency).
REQ-018 LOCK: spi_tx_valid, spi_tx_byte and spi_tx_clear_cs SHALL be combinational pass-throughs of the owner's valid, byte and last; the non-owner's ready SHALL be 0.
REQ-019 LOCK SHALL persist across any number of bytes and owner valid-low stalls until a byte with last=1 transfers; the grant SHALL never move mid-transaction, so CS framing is never interleaved.
REQ-020 On transfer of a last=1 byte: state -> GAP with grant cleared when GAP_CYCLES>0; state -> IDLE when GAP_CYCLES=0.
REQ-021 GAP SHALL count exactly GAP_CYCLES cycles with a 4-bit counter, then enter IDLE; requests during GAP SHALL be held off (ready 0).
REQ-022 Simultaneous requests in IDLE SHALL resolve by the priority rule in Configuration.
REQ-023 A single-byte transaction (last=1 on first byte) SHALL be legal and behave per REQ-020.
REQ-024 spi_tx_ready low on LOCK entry SHALL stall without loss; the owner's byte SHALL be held by the requester, not buffered here.

Reset
REQ-025 On reset_n low, immediately: state IDLE, grant 2'b00, busy 0, spi_tx_valid 0, req0_ready 0, req1_ready 0, GAP counter 0, priority pointer to requester 0.
REQ-026 Reset asserted mid-transaction SHALL abandon the lock; the SPI master is reset from the same source.
REQ-027 Reset deassertion SHALL be synchronised externally; no request SHALL be granted on the first edge after deassertion.

Configuration
REQ-028 Macro SPI_TX_ARBITER_ROUND_ROBIN_EN: when defined, a 1-bit pointer SHALL record the last owner and, on simultaneous requests, the other requester SHALL win; when undefined, requester 0 SHALL always win ties and no pointer register exists.

Structure
REQ-029 Shared package spi_arb_pkg SHALL hold the state encoding (IDLE, LOCK, GAP), GRANT_NONE/GRANT_0/GRANT_1 constants and the GAP counter width.
REQ-030 A sub-module spi_arb_pick (two-request winner selection, pointer input) is natural and SHALL hold the only priority logic.

Verification
REQ-031 req0 only, 3 bytes 8'h26,8'hE3,8'h1C, last on third, spi_tx_ready always 1 -> grant 2'b01 one cycle after valid, bytes out in order, clear_cs high only with 8'h1C, busy 0 after 2 gap cycles.
REQ-032 req0 and req1 valid same cycle, fixed-priority build -> req0 wins twice in a row; round-robin build -> req0 then req1.
REQ-033 req1 owns lock and drops valid 5 cycles mid-transaction while req0 is valid -> grant stays 2'b10, req0_ready stays 0 until req1 last byte transfers plus GAP.
REQ-034 spi_tx_ready held 0 for 10 cycles during LOCK -> spi_tx_valid stays 1, byte stable, no transfer counted.
REQ-035 reset_n pulsed low mid-transaction after byte 2 of 4 -> all outputs at REQ-025 values during reset, next grant starts a fresh transaction.
REQ-036 GAP_CYCLES=0 with back-to-back single-byte requests from req0 -> new grant one cycle after previous last-byte transfer.
